mod_count_fsm: RTL and testbench
================================

MOD_COUNT_FSM -- requirements
Module: mod_count_fsm

Interface
REQ-001 SHALL have parameter MOD, default 2, modulus applied to both symbol counts; legal range 2..16.
REQ-002 SHALL have parameter W, default 1, input bits consumed per valid cycle; legal range 1..32.
REQ-003 SHALL have derived width RW = max(1, ceil(log2(MOD))), used for all residue and target ports.
REQ-004 SHALL have port clk  input  1  sole clock; all flops rising-edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port clr  input  1  synchronous clear of residues and flags.
REQ-007 SHALL have port in_valid  input  1  qualifies in_data this cycle.
REQ-008 SHALL have port in_data  input  W  bit group to be counted.
REQ-009 SHALL have port tgt_zeros  input  RW  target residue for zero count.
REQ-010 SHALL have port tgt_ones  input  RW  target residue for one count.
REQ-011 SHALL have port zero_res  output  RW  registered zero count mod MOD.
REQ-012 SHALL have port one_res  output  RW  registered one count mod MOD.
REQ-013 SHALL have port zero_wrap  output  1  registered one-cycle pulse on zero-count wrap.
REQ-014 SHALL have port one_wrap  output  1  registered one-cycle pulse on one-count wrap.
REQ-015 SHALL have port match  output  1  residues equal targets.

Function
REQ-016 SHALL keep state {zero_res, one_res}, MOD*MOD states; MOD=2, W=1 gives the 4-state even/odd 0s/1s machine (S00..S11).
REQ-017 SHALL, on a cycle with in_valid=1, take k = popcount(in_data); at the edge, one_res <= (one_res + k) mod MOD and zero_res <= (zero_res + W - k) mod MOD; latency 1 cycle.
REQ-018 SHALL hold both residues when in_valid=0, and drive both wrap flags 0 in that cycle.
REQ-019 SHALL pulse one_wrap (zero_wrap) for exactly the cycle after an update where the unreduced sum is >= MOD; a sum that spans several multiples of MOD still gives one pulse.
REQ-020 SHALL compute sums at full width without overflow for every legal MOD/W; an update with k=0 or k=W leaves the untouched residue unchanged and its wrap flag 0.
REQ-021 SHALL drive match as a combinational compare: (zero_res==tgt_zeros) && (one_res==tgt_ones), using registered residues and current targets; a target >= MOD never matches.
REQ-022 SHALL give clr priority over in_valid: zero_res, one_res, zero_wrap and one_wrap go to 0 at the edge, and in_data that cycle is discarded.
REQ-023 SHALL give rst priority over clr and in_valid.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set zero_res=0, one_res=0, zero_wrap=0, one_wrap=0 and any sticky match state to 0; match then reflects targets against 0.
REQ-025 SHALL discard any in-flight update when rst is asserted mid-stream; counting restarts from 0 on the first valid cycle after rst falls.

Configuration
REQ-026 SHALL use macro MATCH_STICKY_EN; when undefined, match is exactly the REQ-021 compare.
REQ-027 SHALL, when MATCH_STICKY_EN is defined, add a flop that sets at any edge where the raw compare is 1 and clears only on rst or clr; match = raw compare OR flop, so it rises with the raw compare and stays high.

Verification
REQ-028 SHALL check MOD=2, W=1, from reset, stream 0,1,1,0 (all valid): (zero_res, one_res) after each edge = (1,0),(1,1),(1,0),(0,0); one_wrap pulses after the 3rd edge, zero_wrap after the 4th.
REQ-029 SHALL check MOD=3, W=4, from reset: 4'b1011 gives one_res=0, zero_res=1, one_wrap=1; then 4'b0001 gives one_res=1, zero_res=1, zero_wrap=1.
REQ-030 SHALL check MOD=2, W=1, tgt_zeros=1, tgt_ones=1: after inputs 0,1 match=1; after a further 1, match=0 without the macro and match=1 with MATCH_STICKY_EN.
REQ-031 SHALL check clr and in_valid high together with in_data=1 on residues (1,1): the next cycle gives (0,0), wrap flags 0, sticky match cleared.
REQ-032 SHALL check rst high for 1 cycle mid-stream, residues (1,0), MOD=2: all outputs 0; then input 1 gives (0,1).
REQ-033 SHALL check in_valid=0 for 5 cycles with toggling in_data: residues unchanged and wrap flags 0 throughout.

Source files
------------

// File: rtl/mod_count_fsm.sv
// Counts 0s and 1s of each valid W-bit input group modulo MOD, with wrap pulses and a target match.
// Optional macro MATCH_STICKY_EN: match latches high until rst or clr.
module mod_count_fsm #(
  parameter int MOD = 2,
  parameter int W   = 1,
  localparam int RW = (MOD > 2) ? $clog2(MOD) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic [RW-1:0] tgt_zeros,
  input  logic [RW-1:0] tgt_ones,
  output logic [RW-1:0] zero_res,
  output logic [RW-1:0] one_res,
  output logic          zero_wrap,
  output logic          one_wrap,
  output logic          match
);

  // Sum width holds the largest residue plus a full group of W bits.
  localparam int SW = $clog2(MOD + W) + 1;
  localparam logic [SW-1:0] MOD_S = SW'(MOD);
  localparam logic [SW-1:0] W_S   = SW'(W);

  logic [RW-1:0] r_zero_res;
  logic [RW-1:0] r_one_res;
  logic          r_zero_wrap;
  logic          r_one_wrap;

  logic [SW-1:0] w_k;
  logic [SW-1:0] w_zero_sum;
  logic [SW-1:0] w_one_sum;
  logic [RW-1:0] w_zero_next;
  logic [RW-1:0] w_one_next;
  logic          w_raw_match;

  always_comb begin
    w_k = '0;
    for (int i = 0; i < W; i++) begin
      w_k = w_k + SW'(in_data[i]);
    end
  end

  assign w_one_sum   = SW'(r_one_res) + w_k;
  assign w_zero_sum  = SW'(r_zero_res) + (W_S - w_k);
  assign w_one_next  = RW'(w_one_sum % MOD_S);
  assign w_zero_next = RW'(w_zero_sum % MOD_S);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero_res  <= '0;
      r_one_res   <= '0;
      r_zero_wrap <= 1'b0;
      r_one_wrap  <= 1'b0;
    end else if (clr) begin
      r_zero_res  <= '0;
      r_one_res   <= '0;
      r_zero_wrap <= 1'b0;
      r_one_wrap  <= 1'b0;
    end else if (in_valid) begin
      r_zero_res  <= w_zero_next;
      r_one_res   <= w_one_next;
      // A wrap is any unreduced sum reaching MOD, however many multiples it spans.
      r_zero_wrap <= (w_zero_sum >= MOD_S);
      r_one_wrap  <= (w_one_sum >= MOD_S);
    end else begin
      r_zero_wrap <= 1'b0;
      r_one_wrap  <= 1'b0;
    end
  end

  // Residues are always below MOD, so an out-of-range target can never compare equal.
  assign w_raw_match = (r_zero_res == tgt_zeros) && (r_one_res == tgt_ones);

`ifdef MATCH_STICKY_EN
  logic r_match_sticky;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_match_sticky <= 1'b0;
    end else if (w_raw_match) begin
      r_match_sticky <= 1'b1;
    end
  end

  assign match = w_raw_match | r_match_sticky;
`else
  assign match = w_raw_match;
`endif

  assign zero_res  = r_zero_res;
  assign one_res   = r_one_res;
  assign zero_wrap = r_zero_wrap;
  assign one_wrap  = r_one_wrap;

endmodule

// File: tb/tb_mod_count_fsm.sv
// Bench for mod_count_fsm: three instances (MOD/W = 2/1, 3/4, 5/7) against a total-count model.
`timescale 1ns/1ps
module tb_mod_count_fsm;

`ifdef MATCH_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: MOD=2, W=1
  logic       a_rst = 1'b1, a_clr = 1'b0, a_vld = 1'b0;
  logic [0:0] a_dat = '0, a_tz = '0, a_to = '0;
  logic [0:0] a_zr, a_or;
  logic       a_zw, a_ow, a_m;
  // Instance B: MOD=3, W=4
  logic       b_rst = 1'b1, b_clr = 1'b0, b_vld = 1'b0;
  logic [3:0] b_dat = '0;
  logic [1:0] b_tz = '0, b_to = '0;
  logic [1:0] b_zr, b_or;
  logic       b_zw, b_ow, b_m;
  // Instance C: MOD=5, W=7
  logic       c_rst = 1'b1, c_clr = 1'b0, c_vld = 1'b0;
  logic [6:0] c_dat = '0;
  logic [2:0] c_tz = '0, c_to = '0;
  logic [2:0] c_zr, c_or;
  logic       c_zw, c_ow, c_m;

  mod_count_fsm #(.MOD(2), .W(1)) u_a (
    .clk(clk), .rst(a_rst), .clr(a_clr), .in_valid(a_vld), .in_data(a_dat),
    .tgt_zeros(a_tz), .tgt_ones(a_to), .zero_res(a_zr), .one_res(a_or),
    .zero_wrap(a_zw), .one_wrap(a_ow), .match(a_m)
  );
  mod_count_fsm #(.MOD(3), .W(4)) u_b (
    .clk(clk), .rst(b_rst), .clr(b_clr), .in_valid(b_vld), .in_data(b_dat),
    .tgt_zeros(b_tz), .tgt_ones(b_to), .zero_res(b_zr), .one_res(b_or),
    .zero_wrap(b_zw), .one_wrap(b_ow), .match(b_m)
  );
  mod_count_fsm #(.MOD(5), .W(7)) u_c (
    .clk(clk), .rst(c_rst), .clr(c_clr), .in_valid(c_vld), .in_data(c_dat),
    .tgt_zeros(c_tz), .tgt_ones(c_to), .zero_res(c_zr), .one_res(c_or),
    .zero_wrap(c_zw), .one_wrap(c_ow), .match(c_m)
  );

  // Model: total zeros/ones seen since the last rst/clr; residues and wraps derive from them.
  int md[3] = '{2, 3, 5};
  int wd[3] = '{1, 4, 7};
  int m_c0[3] = '{0, 0, 0};
  int m_c1[3] = '{0, 0, 0};
  bit m_w0[3] = '{0, 0, 0};
  bit m_w1[3] = '{0, 0, 0};
  bit m_st[3] = '{0, 0, 0};

  function automatic bit exp_match(int d, int tz, int to);
    bit raw;
    raw = ((m_c0[d] % md[d]) == tz) && ((m_c1[d] % md[d]) == to);
    return raw || (STICKY && m_st[d]);
  endfunction

  // Advance the model from the currently driven inputs, then clock and settle.
  task automatic tick();
    int rs[3], cl[3], vl[3], kk[3], tz[3], to[3];
    bit raw;
    rs[0] = int'(a_rst); rs[1] = int'(b_rst); rs[2] = int'(c_rst);
    cl[0] = int'(a_clr); cl[1] = int'(b_clr); cl[2] = int'(c_clr);
    vl[0] = int'(a_vld); vl[1] = int'(b_vld); vl[2] = int'(c_vld);
    kk[0] = $countones(a_dat); kk[1] = $countones(b_dat); kk[2] = $countones(c_dat);
    tz[0] = int'(a_tz); tz[1] = int'(b_tz); tz[2] = int'(c_tz);
    to[0] = int'(a_to); to[1] = int'(b_to); to[2] = int'(c_to);
    for (int d = 0; d < 3; d++) begin
      raw = ((m_c0[d] % md[d]) == tz[d]) && ((m_c1[d] % md[d]) == to[d]);
      if (rs[d] != 0 || cl[d] != 0) begin
        m_c0[d] = 0; m_c1[d] = 0; m_w0[d] = 0; m_w1[d] = 0; m_st[d] = 0;
      end else begin
        if (vl[d] != 0) begin
          m_w1[d] = ((m_c1[d] + kk[d]) / md[d]) > (m_c1[d] / md[d]);
          m_w0[d] = ((m_c0[d] + wd[d] - kk[d]) / md[d]) > (m_c0[d] / md[d]);
          m_c1[d] = m_c1[d] + kk[d];
          m_c0[d] = m_c0[d] + wd[d] - kk[d];
        end else begin
          m_w0[d] = 0; m_w1[d] = 0;
        end
        if (raw) m_st[d] = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_rst = 1'b1; a_clr = 1'b0; a_vld = 1'b0;
    tick();
    a_rst = 1'b0;
  endtask

  task automatic test_reset();
    a_tz = '0; a_to = '0; b_tz = '0; b_to = '0;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    total++;
    $display("reset A: res=(%0d,%0d) wrap=(%b,%b) match=%b", a_zr, a_or, a_zw, a_ow, a_m);
    if ({a_zr, a_or, a_zw, a_ow, a_m} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_a: got %b want 00001", {a_zr, a_or, a_zw, a_ow, a_m});
    end
    total++;
    $display("reset B: res=(%0d,%0d) wrap=(%b,%b) match=%b", b_zr, b_or, b_zw, b_ow, b_m);
    if ({b_zr, b_or, b_zw, b_ow, b_m} !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_b: got %b want 0000001", {b_zr, b_or, b_zw, b_ow, b_m});
    end
  endtask

  task automatic test_seq_mod2();
    logic       din [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] ex  [4] = '{4'b1000, 4'b1100, 4'b1001, 4'b0010};
    reset_a();
    for (int i = 0; i < 4; i++) begin
      a_vld = 1'b1; a_dat = din[i];
      tick();
      total++;
      $display("seq_mod2 in=%b: res=(%0d,%0d) wrap=(%b,%b)", din[i], a_zr, a_or, a_zw, a_ow);
      if ({a_zr, a_or, a_zw, a_ow} !== ex[i]) begin
        bad++;
        $display("FAIL seq_mod2[%0d]: got %b want %b", i, {a_zr, a_or, a_zw, a_ow}, ex[i]);
      end
    end
    a_vld = 1'b0;
  endtask

  task automatic test_mod3_w4();
    b_rst = 1'b1; tick(); b_rst = 1'b0;
    b_vld = 1'b1; b_dat = 4'b1011;
    tick();
    total++;
    $display("mod3_w4 in=1011: res=(%0d,%0d) wrap=(%b,%b)", b_zr, b_or, b_zw, b_ow);
    if ({b_zr, b_or, b_zw, b_ow} !== {2'd1, 2'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mod3_w4_first: got %b want 01_00_0_1", {b_zr, b_or, b_zw, b_ow});
    end
    b_dat = 4'b0001;
    tick();
    total++;
    $display("mod3_w4 in=0001: res=(%0d,%0d) wrap=(%b,%b)", b_zr, b_or, b_zw, b_ow);
    if ({b_zr, b_or, b_zw, b_ow} !== {2'd1, 2'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL mod3_w4_second: got %b want 01_01_1_0", {b_zr, b_or, b_zw, b_ow});
    end
    b_vld = 1'b0;
  endtask

  task automatic test_match();
    reset_a();
    a_tz = 1'b1; a_to = 1'b1;
    a_vld = 1'b1; a_dat = 1'b0; tick();
    a_dat = 1'b1; tick();
    total++;
    $display("match after 0,1: res=(%0d,%0d) match=%b", a_zr, a_or, a_m);
    if (a_m !== 1'b1) begin
      bad++;
      $display("FAIL match_hit: got %b want 1", a_m);
    end
    a_dat = 1'b1; tick();
    a_vld = 1'b0;
    total++;
    $display("match after 0,1,1: res=(%0d,%0d) match=%b", a_zr, a_or, a_m);
    if (a_m !== STICKY) begin
      bad++;
      $display("FAIL match_after_leave: got %b want %b", a_m, STICKY);
    end
  endtask

  task automatic test_clr();
    reset_a();
    a_tz = 1'b1; a_to = 1'b1;
    a_vld = 1'b1; a_dat = 1'b0; tick();
    a_dat = 1'b1; tick();
    a_clr = 1'b1; a_dat = 1'b1; tick();
    a_clr = 1'b0; a_vld = 1'b0;
    total++;
    $display("clr: res=(%0d,%0d) wrap=(%b,%b) match=%b", a_zr, a_or, a_zw, a_ow, a_m);
    if ({a_zr, a_or, a_zw, a_ow, a_m} !== 5'b00000) begin
      bad++;
      $display("FAIL clr_priority: got %b want 00000", {a_zr, a_or, a_zw, a_ow, a_m});
    end
    tick();
    total++;
    $display("clr+1 idle: res=(%0d,%0d) match=%b", a_zr, a_or, a_m);
    if (a_m !== 1'b0) begin
      bad++;
      $display("FAIL clr_sticky_cleared: got %b want 0", a_m);
    end
  endtask

  task automatic test_rst_mid();
    reset_a();
    a_tz = 1'b1; a_to = 1'b1;
    a_vld = 1'b1; a_dat = 1'b0; tick();
    total++;
    $display("rst_mid pre: res=(%0d,%0d)", a_zr, a_or);
    if ({a_zr, a_or} !== 2'b10) begin
      bad++;
      $display("FAIL rst_mid_pre: got %b want 10", {a_zr, a_or});
    end
    a_rst = 1'b1; a_dat = 1'b1; tick();
    a_rst = 1'b0;
    total++;
    $display("rst_mid rst: res=(%0d,%0d) wrap=(%b,%b) match=%b", a_zr, a_or, a_zw, a_ow, a_m);
    if ({a_zr, a_or, a_zw, a_ow, a_m} !== 5'b00000) begin
      bad++;
      $display("FAIL rst_mid_clear: got %b want 00000", {a_zr, a_or, a_zw, a_ow, a_m});
    end
    a_dat = 1'b1; tick();
    a_vld = 1'b0;
    total++;
    $display("rst_mid restart: res=(%0d,%0d) wrap=(%b,%b)", a_zr, a_or, a_zw, a_ow);
    if ({a_zr, a_or, a_zw, a_ow} !== 4'b0100) begin
      bad++;
      $display("FAIL rst_mid_restart: got %b want 0100", {a_zr, a_or, a_zw, a_ow});
    end
  endtask

  task automatic test_idle();
    b_rst = 1'b1; tick(); b_rst = 1'b0;
    b_vld = 1'b1; b_dat = 4'b1011; tick();
    b_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_dat = ~b_dat;
      tick();
      total++;
      $display("idle[%0d] dat=%b: res=(%0d,%0d) wrap=(%b,%b)", i, b_dat, b_zr, b_or, b_zw, b_ow);
      if ({b_zr, b_or, b_zw, b_ow} !== {2'd1, 2'd0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL idle_hold[%0d]: got %b want 01_00_0_0", i, {b_zr, b_or, b_zw, b_ow});
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] az, ao, ez, eo;
    logic       azw, aow, am, ezw, eow, em;
    for (int n = 0; n < 300; n++) begin
      a_rst = ($urandom_range(49) == 0); b_rst = ($urandom_range(49) == 0); c_rst = ($urandom_range(49) == 0);
      a_clr = ($urandom_range(19) == 0); b_clr = ($urandom_range(19) == 0); c_clr = ($urandom_range(19) == 0);
      a_vld = ($urandom_range(3) != 0);  b_vld = ($urandom_range(3) != 0);  c_vld = ($urandom_range(3) != 0);
      a_dat = 1'($urandom); b_dat = 4'($urandom); c_dat = 7'($urandom);
      a_tz = 1'($urandom); a_to = 1'($urandom);
      b_tz = 2'($urandom); b_to = 2'($urandom);
      c_tz = 3'($urandom); c_to = 3'($urandom);
      tick();
      for (int d = 0; d < 3; d++) begin
        ez = 8'(m_c0[d] % md[d]); eo = 8'(m_c1[d] % md[d]);
        ezw = m_w0[d]; eow = m_w1[d];
        case (d)
          0: begin
            az = 8'(a_zr); ao = 8'(a_or); azw = a_zw; aow = a_ow; am = a_m;
            em = exp_match(d, int'(a_tz), int'(a_to));
          end
          1: begin
            az = 8'(b_zr); ao = 8'(b_or); azw = b_zw; aow = b_ow; am = b_m;
            em = exp_match(d, int'(b_tz), int'(b_to));
          end
          default: begin
            az = 8'(c_zr); ao = 8'(c_or); azw = c_zw; aow = c_ow; am = c_m;
            em = exp_match(d, int'(c_tz), int'(c_to));
          end
        endcase
        total++;
        if (az !== ez || ao !== eo || azw !== ezw || aow !== eow || am !== em) begin
          bad++;
          $display("FAIL random[%0d] dut%0d: got res=(%0d,%0d) wrap=(%b,%b) match=%b want res=(%0d,%0d) wrap=(%b,%b) match=%b",
                   n, d, az, ao, azw, aow, am, ez, eo, ezw, eow, em);
        end
      end
      $display("random[%0d]: A=(%0d,%0d) B=(%0d,%0d) C=(%0d,%0d)", n, a_zr, a_or, b_zr, b_or, c_zr, c_or);
    end
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
    a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_seq_mod2();
    test_mod3_w4();
    test_match();
    test_clr();
    test_rst_mid();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
